mips_trace_capture: RTL

- Synthesizable on-chip trace recorder for the single-cycle MIPS datapath.
- It watches the CPU's observation outputs (PC, instruction, ALU result) and, once armed, waits for a trigger PC.
- After the trigger it records one entry per clock into a DEPTH-entry buffer.
- It then drains the buffer to a host over a valid/ready word stream.
- It sits beside the CPU and consumes the same outputs a stimulus bench drives the CPU to produce: the observing end of that clock/reset-driven interface.

---
 rtl/mips_trace_capture.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mips_trace_capture.sv
// mips_trace_capture: on-chip trace recorder for the single-cycle MIPS core.
// Arms on request, waits for PCout == trig_pc, records one entry per clock
// into a DEPTH-entry buffer, then drains it oldest-first over a word stream.
//
// Optional feature macro: TRACE_ALU_EN
//   defined   -> each entry also stores ALUOut; 3 words per entry (PC, inst, ALU)
//   undefined -> no ALU storage; 2 words per entry (PC, inst)
//
// Stream handshake: out_valid is high only in DRAIN; a word moves on a rising
// edge where out_valid and out_ready are both 1; while out_valid=1 and
// out_ready=0, out_data and out_last hold stable; out_last marks the final
// word of the final entry.
module mips_trace_capture #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             arm,
  input  logic             stop,
  input  logic [31:0]      trig_pc,
  input  logic [31:0]      PCout,
  input  logic [31:0]      inst,
  input  logic [31:0]      ALUOut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic [1:0]       state,
  output logic [PTR_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

`ifdef TRACE_ALU_EN
  localparam int WPE = 3;
`else
  localparam int WPE = 2;
`endif
  localparam logic [1:0]     LAST_WORD = 2'(WPE - 1);
  localparam logic [PTR_W:0] FULL_M1   = (PTR_W+1)'(DEPTH - 1);
  localparam logic [PTR_W:0] ONE       = (PTR_W+1)'(1);

  state_t           state_q, state_d;
  logic [PTR_W:0]   count_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       word_idx;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
`ifdef TRACE_ALU_EN
  logic [31:0] alu_mem  [DEPTH];
`else
  logic unused_alu;
  assign unused_alu = ^ALUOut;
`endif

  logic trig_hit;
  logic wr_en;
  logic cap_full;
  logic xfer;
  logic last_word;

  // Stop beats a trigger match in ARMED; matches are only looked for in ARMED.
  assign trig_hit  = (state_q == ARMED) && !stop && (PCout == trig_pc);
  assign wr_en     = trig_hit || (state_q == CAPTURE);
  // The write happening this cycle fills the last free slot.
  assign cap_full  = (count_q == FULL_M1);
  assign xfer      = out_valid && out_ready;
  assign last_word = (word_idx == LAST_WORD) && ({1'b0, rd_ptr} == (count_q - ONE));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = ARMED;
      ARMED: begin
        if (stop)          state_d = IDLE;
        else if (trig_hit) state_d = CAPTURE;
      end
      CAPTURE: if (stop || cap_full) state_d = DRAIN;
      DRAIN:   if (xfer && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Entry count and write pointer; both restart from zero for each capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wr_ptr  <= '0;
    end else begin
      if (state_q == IDLE) begin
        count_q <= '0;
        wr_ptr  <= '0;
      end else if (wr_en) begin
        count_q <= count_q + ONE;
        // Hold the pointer on the final write rather than wrapping it.
        if (!((state_q == CAPTURE) && cap_full)) wr_ptr <= wr_ptr + 1'b1;
      end else if ((state_q == DRAIN) && xfer && last_word) begin
        count_q <= '0;
      end
    end
  end

  // Read pointer and word index; held at zero outside DRAIN so each drain starts at entry 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      word_idx <= '0;
    end else if (state_q != DRAIN) begin
      rd_ptr   <= '0;
      word_idx <= '0;
    end else if (xfer) begin
      if (word_idx == LAST_WORD) begin
        word_idx <= '0;
        rd_ptr   <= rd_ptr + 1'b1;
      end else begin
        word_idx <= word_idx + 2'd1;
      end
    end
  end

  // Trace buffer; contents need no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= PCout;
      inst_mem[wr_ptr] <= inst;
`ifdef TRACE_ALU_EN
      alu_mem[wr_ptr]  <= ALUOut;
`endif
    end
  end

  // Output word selection from the registered read pointer; zero when not draining.
  always_comb begin
    out_valid = (state_q == DRAIN);
    out_data  = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_last = last_word;
      case (word_idx)
        2'd0:    out_data = pc_mem[rd_ptr];
        2'd1:    out_data = inst_mem[rd_ptr];
`ifdef TRACE_ALU_EN
        2'd2:    out_data = alu_mem[rd_ptr];
`endif
        default: out_data = '0;
      endcase
    end
  end

  assign state = state_q;
  assign count = count_q;

endmodule
